// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32 control path.
// Build option: MCCTRL_ADDI_EN adds the EXECI state for opcode 0010011.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_TRAP     = 4'd9
`ifdef MCCTRL_ADDI_EN
    , ST_EXECI  = 4'd10
`endif
  } mc_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // Same encoding the ALU control decoder expects.
  localparam logic [1:0] ALUOP_LWSW   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_word_t;

  function automatic ctrl_word_t ctrl_idle();
    ctrl_word_t w;
    w       = '0;
    w.aluop = ALUOP_LWSW;
    return w;
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control-word decoder for multicycle_ctrl.
// Build option: MCCTRL_ADDI_EN decodes the EXECI state.
module mc_outdec
  import ctrl_pkg::*;
(
  input  mc_state_t  state,
  input  logic       ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = ctrl_idle();
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC load only on the cycle the fetch actually completes.
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_BOFF;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.aluop     = ALUOP_RTYPE;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RS2;
        ctrl.aluop         = ALUOP_BRANCH;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
`ifdef MCCTRL_ADDI_EN
      ST_EXECI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
`endif
      // TRAP and any stray encoding: everything idle, flag raised.
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 datapath (fetch/decode/execute/mem/wb).
// Build option: MCCTRL_ADDI_EN enables addi via the EXECI state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state_o
);

  mc_state_t  state;
  logic       is_store;
  logic       ready;
  ctrl_word_t ctrl;
  ctrl_word_t ctrl_out;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      is_store <= 1'b0;
    end else begin
      case (state)
        ST_FETCH:    state <= ready ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          // The IR may change later, so remember load vs store now.
          is_store <= (opcode == OP_STORE);
          case (opcode)
            OP_LOAD, OP_STORE: state <= ST_MEMADR;
            OP_RTYPE:          state <= ST_EXECUTE;
            OP_BRANCH:         state <= ST_BRANCH;
`ifdef MCCTRL_ADDI_EN
            OP_IMM:            state <= ST_EXECI;
`endif
            default:           state <= ST_TRAP;
          endcase
        end
        ST_MEMADR:   state <= is_store ? ST_MEMWRITE : ST_MEMREAD;
        ST_MEMREAD:  state <= ready ? ST_MEMWB : ST_MEMREAD;
        ST_MEMWB:    state <= ST_FETCH;
        ST_MEMWRITE: state <= ready ? ST_FETCH : ST_MEMWRITE;
        ST_EXECUTE:  state <= ST_ALUWB;
        ST_ALUWB:    state <= ST_FETCH;
        ST_BRANCH:   state <= ST_FETCH;
`ifdef MCCTRL_ADDI_EN
        ST_EXECI:    state <= ST_ALUWB;
`endif
        default:     state <= ST_TRAP;
      endcase
    end
  end

  mc_outdec u_outdec (
    .state (state),
    .ready (ready),
    .ctrl  (ctrl)
  );

  // Reset forces every output low immediately, so an in-flight access is dropped.
  assign ctrl_out      = rst ? '0 : ctrl;
  assign state_o       = rst ? 4'd0 : state;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign aluop         = ctrl_out.aluop;
  assign pc_source     = ctrl_out.pc_source;
  assign illegal       = ctrl_out.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: expected per-cycle behaviour is built from the instruction class.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic [3:0] state_o;
  logic [15:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_BAD} kind_t;
  typedef struct {
    mc_state_t st;
    logic      rdy;
  } step_t;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .pc_source(pc_source),
    .illegal(illegal), .state_o(state_o)
  );

  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop, pc_source, illegal};

  // Control word each state must present, written from the state table.
  function automatic logic [15:0] exp_ctrl(mc_state_t s, logic rdy);
    logic pcw, pcwc, ia, mr, mw, irw, m2r, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, ia, mr, mw, irw, m2r, rw, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      ST_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE:   begin asb = 2'b11; end
      ST_MEMADR:   begin asa = 1; asb = 2'b10; end
      ST_MEMREAD:  begin mr = 1; ia = 1; end
      ST_MEMWB:    begin rw = 1; m2r = 1; end
      ST_MEMWRITE: begin mw = 1; ia = 1; end
      ST_EXECUTE:  begin asa = 1; aop = 2'b10; end
      ST_ALUWB:    begin rw = 1; end
      ST_BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
`ifdef MCCTRL_ADDI_EN
      ST_EXECI:    begin asa = 1; asb = 2'b10; end
`endif
      default:     begin ill = 1; end
    endcase
    return {pcw, pcwc, ia, mr, mw, irw, m2r, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [6:0] kind_op(kind_t k);
    case (k)
      K_LW:    return OP_LOAD;
      K_SW:    return OP_STORE;
      K_R:     return OP_RTYPE;
      K_BEQ:   return OP_BRANCH;
      K_ADDI:  return OP_IMM;
      default: return 7'b0001111;
    endcase
  endfunction

  // One cycle: drive inputs, check state and control word mid-cycle, advance.
  task automatic step(input mc_state_t st, input logic rdy, input logic [6:0] op, input string tag);
    mem_ready = rdy;
    opcode    = (st == ST_DECODE) ? op : 7'($urandom);
    @(negedge clk);
    n_tests++;
    if (state_o !== st) begin
      n_fail++;
      $display("FAIL %s state: got %0d want %0d", tag, state_o, st);
    end
    n_tests++;
    if (obs !== exp_ctrl(st, rdy)) begin
      n_fail++;
      $display("FAIL %s ctrl in state %0d: got %h want %h", tag, st, obs, exp_ctrl(st, rdy));
    end
    @(posedge clk); #1;
  endtask

  // Expected cycle-by-cycle walk of one instruction with given wait counts.
  task automatic run_instr(input kind_t k, input int fw, input int mw, input string tag);
    step_t q[$];
    logic [6:0] op;
    op = kind_op(k);
    for (int i = 0; i < fw; i++) q.push_back('{ST_FETCH, 1'b0});
    q.push_back('{ST_FETCH, 1'b1});
    q.push_back('{ST_DECODE, 1'($urandom)});
    case (k)
      K_LW: begin
        q.push_back('{ST_MEMADR, 1'($urandom)});
        for (int i = 0; i < mw; i++) q.push_back('{ST_MEMREAD, 1'b0});
        q.push_back('{ST_MEMREAD, 1'b1});
        q.push_back('{ST_MEMWB, 1'($urandom)});
      end
      K_SW: begin
        q.push_back('{ST_MEMADR, 1'($urandom)});
        for (int i = 0; i < mw; i++) q.push_back('{ST_MEMWRITE, 1'b0});
        q.push_back('{ST_MEMWRITE, 1'b1});
      end
      K_R: begin
        q.push_back('{ST_EXECUTE, 1'($urandom)});
        q.push_back('{ST_ALUWB, 1'($urandom)});
      end
      K_BEQ: q.push_back('{ST_BRANCH, 1'($urandom)});
`ifdef MCCTRL_ADDI_EN
      K_ADDI: begin
        q.push_back('{ST_EXECI, 1'($urandom)});
        q.push_back('{ST_ALUWB, 1'($urandom)});
      end
`endif
      default: q.push_back('{ST_TRAP, 1'($urandom)});
    endcase
    foreach (q[i]) step(q[i].st, q[i].rdy, op, tag);
  endtask

  // Leaves the DUT at the start of a FETCH cycle, inputs aligned 1ns after the edge.
  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 7'($urandom);
      @(negedge clk);
      n_tests++;
      if (obs !== 16'h0 || state_o !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got ctrl %h state %0d want 0000 / 0", obs, state_o);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    step(ST_FETCH, 1'b1, OP_RTYPE, "reset_release");
    step(ST_DECODE, 1'b1, OP_RTYPE, "reset_release");
    step(ST_EXECUTE, 1'b1, OP_RTYPE, "reset_release");
    step(ST_ALUWB, 1'b1, OP_RTYPE, "reset_release");
  endtask

  task automatic test_rtype();
    run_instr(K_R, 0, 0, "rtype");
    run_instr(K_R, 2, 0, "rtype_fwait");
  endtask

  task automatic test_latency();
    logic [6:0] ops[4];
    int lat[4];
    int cnt;
    ops = '{OP_BRANCH, OP_RTYPE, OP_STORE, OP_LOAD};
    lat = '{3, 4, 4, 5};
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      opcode    = ops[i];
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
      end while (state_o != ST_FETCH && cnt < 20);
      n_tests++;
      if (cnt != lat[i]) begin
        n_fail++;
        $display("FAIL latency op=%b: got %0d cycles want %0d", ops[i], cnt, lat[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    int cnt = 0, waits = 2, wb = 0, held_bad = 0;
    opcode = OP_LOAD;
    do begin
      if (state_o == ST_MEMREAD && waits > 0) begin
        mem_ready = 1'b0;
        waits--;
      end else begin
        mem_ready = 1'b1;
      end
      if (state_o == ST_MEMREAD && (mem_read !== 1'b1 || iord !== 1'b1)) held_bad++;
      if (state_o == ST_MEMWB) begin
        wb++;
        if (mem_to_reg !== 1'b1) held_bad++;
      end
      @(posedge clk); #1;
      cnt++;
    end while (state_o != ST_FETCH && cnt < 30);
    mem_ready = 1'b1;
    n_tests++;
    if (cnt != 7) begin
      n_fail++;
      $display("FAIL lw_wait latency: got %0d want 7", cnt);
    end
    n_tests++;
    if (wb != 1 || held_bad != 0) begin
      n_fail++;
      $display("FAIL lw_wait memwb_cycles=%0d bad_cycles=%0d want 1 and 0", wb, held_bad);
    end
  endtask

  task automatic test_beq();
    run_instr(K_BEQ, 0, 0, "beq");
    run_instr(K_BEQ, 1, 0, "beq_fwait");
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL %s reset outputs: got %h want 0000", tag, obs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_trap();
    run_instr(K_BAD, 0, 0, "trap_entry");
    for (int i = 0; i < 4; i++) step(ST_TRAP, 1'($urandom), 7'($urandom), "trap_sticky");
    reset_pulse("trap_clear");
    step(ST_FETCH, 1'b1, OP_IMM, "trap_clear");
    step(ST_DECODE, 1'b1, OP_IMM, "addi");
`ifdef MCCTRL_ADDI_EN
    step(ST_EXECI, 1'b1, OP_IMM, "addi");
    step(ST_ALUWB, 1'b1, OP_IMM, "addi");
`else
    step(ST_TRAP, 1'b1, OP_IMM, "addi_trap");
    step(ST_TRAP, 1'b1, OP_IMM, "addi_trap");
    reset_pulse("addi_clear");
`endif
  endtask

  task automatic test_rst_memwrite();
    step(ST_FETCH, 1'b1, OP_STORE, "sw_rst");
    step(ST_DECODE, 1'b1, OP_STORE, "sw_rst");
    step(ST_MEMADR, 1'b1, OP_STORE, "sw_rst");
    step(ST_MEMWRITE, 1'b0, OP_STORE, "sw_rst");
    step(ST_MEMWRITE, 1'b0, OP_STORE, "sw_rst");
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_write !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0 || obs !== 16'h0) begin
      n_fail++;
      $display("FAIL sw_rst abort: got mem_write=%b ctrl=%h want 0 / 0000", mem_write, obs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(ST_FETCH, 1'b0, OP_STORE, "sw_rst_after");
    step(ST_FETCH, 1'b1, OP_STORE, "sw_rst_after");
    step(ST_DECODE, 1'b1, OP_STORE, "sw_rst_after");
    step(ST_MEMADR, 1'b1, OP_STORE, "sw_rst_after");
    step(ST_MEMWRITE, 1'b1, OP_STORE, "sw_rst_after");
  endtask

  task automatic test_random();
    kind_t k;
    for (int i = 0; i < 40; i++) begin
`ifdef MCCTRL_ADDI_EN
      k = kind_t'($urandom_range(0, 4));
`else
      k = kind_t'($urandom_range(0, 3));
`endif
      run_instr(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_latency();
    test_lw_wait();
    test_beq();
    test_trap();
    test_rst_memwrite();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32 datapath: it sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, and it is the producer of the 2-bit `aluop` consumed by the ALU control decoder. It sits between the instruction register (opcode source) and the datapath, and handshakes with the unified instruction/data memory.

## Interface
Parameters:
- `MEM_HANDSHAKE`, default 1. 1: memory states wait for `mem_ready`. 0: `mem_ready` is ignored and treated as 1.

Ports:
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — synchronous, active-high reset.
- `opcode` in 7 — `instr[6:0]` from the instruction register; sampled only in DECODE.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `pc_write` out 1 — unconditional PC load.
- `pc_write_cond` out 1 — PC load if ALU zero.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_read` out 1 — memory read request.
- `mem_write` out 1 — memory write request.
- `ir_write` out 1 — instruction register load.
- `mem_to_reg` out 1 — writeback select: 0 = ALUOut, 1 = MDR.
- `reg_write` out 1 — register file write enable.
- `alu_src_a` out 1 — ALU A select: 0 = PC, 1 = rs1.
- `alu_src_b` out 2 — ALU B select: 00 = rs2, 01 = const 4, 10 = imm, 11 = branch offset.
- `aluop` out 2 — `ALUOP_LWSW`, `ALUOP_BRANCH` or `ALUOP_RTYPE`.
- `pc_source` out 2 — PC mux select: 00 = ALU result, 01 = ALUOut.
- `illegal` out 1 — sticky unsupported-opcode flag.
- `state_o` out 4 — current state, for debug and bench.

## Operation
- Registered state. Outputs are decoded from state; the only exception is `ir_write`/`pc_write` in FETCH, which are gated by `mem_ready`.
- Any output not listed for a state is 0. `aluop` defaults to `ALUOP_LWSW`.
- **FETCH**
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `aluop`=LWSW, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`.
  - Transition: stay until `mem_ready`, then DECODE.
- **DECODE**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `aluop`=LWSW (precomputes branch target into ALUOut).
  - Dispatch on `opcode`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTE; 1100011 → BRANCH; anything else → TRAP.
- **MEMADR**: `alu_src_a`=1, `alu_src_b`=10, `aluop`=LWSW. Next state is MEMREAD for load, MEMWRITE for store; the opcode is held in a 1-bit registered flag captured in DECODE.
- **MEMREAD**: `mem_read`=1, `iord`=1. Stay until `mem_ready`, then MEMWB.
- **MEMWB**: `reg_write`=1, `mem_to_reg`=1. Next: FETCH.
- **MEMWRITE**: `mem_write`=1, `iord`=1. Stay until `mem_ready`, then FETCH.
- **EXECUTE**: `alu_src_a`=1, `alu_src_b`=00, `aluop`=RTYPE. Next: ALUWB.
- **ALUWB**: `reg_write`=1, `mem_to_reg`=0. Next: FETCH.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=00, `aluop`=BRANCH, `pc_write_cond`=1, `pc_source`=01. Next: FETCH.
- **TRAP**: all enables 0, `illegal`=1. Absorbing until `rst`.
- Any unreachable state encoding goes to TRAP.

## Timing
- During reset: while `rst`=1, all outputs are forced to 0 combinationally, including `mem_write` and `illegal`.
- After reset: state is FETCH on the first edge with `rst`=0, so `mem_read`=1 in that cycle.
- Reset mid-operation: an in-flight MEMWRITE/MEMREAD is abandoned and no `reg_write` or `pc_write` is issued.
- Latency with zero wait states (`mem_ready` always 1):
  - beq: 3 cycles.
  - R-type: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_read`/`mem_write` and `iord` stay stable for the whole wait.
- The `ir_write`/`pc_write` pulse is exactly one cycle, coincident with the `mem_ready` that ends FETCH.
- `pc_write` and `pc_write_cond` are never asserted in the same cycle.

## Configuration
- `MCCTRL_ADDI_EN` defined:
  - DECODE dispatches opcode 0010011 to EXECI: `alu_src_a`=1, `alu_src_b`=10, `aluop`=LWSW.
  - EXECI → ALUWB. addi latency is 4 cycles.
- `MCCTRL_ADDI_EN` undefined: opcode 0010011 goes to TRAP; the EXECI state is not compiled in.

## Structure
- Shared package `ctrl_pkg` holds:
  - the state enum `mc_state_t` (4-bit);
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_BRANCH`, `OP_IMM`;
  - the `ALUOP_LWSW`/`ALUOP_BRANCH`/`ALUOP_RTYPE` values already shared with the ALU control decoder;
  - `alu_src_b` select constants.
- Sub-module `mc_outdec`: purely combinational state → control-word decoder. The top holds the state register, next-state logic, load/store flag and reset gating.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → all outputs 0 during reset; `state_o`=FETCH, `mem_read`=1, `ir_write`=1 on the first cycle after.
- R-type `add` (opcode 0110011), zero wait → FETCH, DECODE, EXECUTE (`aluop`=10), ALUWB (`reg_write`=1, `mem_to_reg`=0), back to FETCH after 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `mem_read`=`iord`=1 held throughout; single MEMWB cycle with `mem_to_reg`=1.
- beq (1100011) → BRANCH has `aluop`=01, `pc_write_cond`=1, `pc_source`=01; 3 cycles; `pc_write`=0 in BRANCH.
- Opcode 0001111 → TRAP; `illegal`=1, no further `mem_read`; cleared only by `rst`. With `MCCTRL_ADDI_EN`, opcode 0010011 → EXECI (`alu_src_b`=10, `aluop`=00) then ALUWB; without it → TRAP.
- `rst` asserted during MEMWRITE wait → `mem_write` drops to 0 in the same cycle; FETCH follows release.
